// File: rtl/data_debounce_pkg.sv
// Shared definitions for the data_debounce block: FSM state encoding and
// default sizing of the stability counter.
package data_debounce_pkg;

   localparam int DEF_STABLE_CYCLES = 4;
   localparam int DEF_CNT_W         = 16;

   // Bit 1 is the accepted level, bit 0 marks a candidate change being counted.
   typedef enum logic [1:0] {
      IDLE_LOW  = 2'b00,
      CHK_HIGH  = 2'b01,
      IDLE_HIGH = 2'b10,
      CHK_LOW   = 2'b11
   } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; both flops clear to 0.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic s1;

   // Metastability filter: first flop may go metastable, second settles it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         q  <= 1'b0;
      end else begin
         s1 <= d;
         q  <= s1;
      end
   end

endmodule

// File: rtl/data_debounce.sv
// Debouncer: synchronizes a raw level, accepts a new level only after it has
// been held for STABLE_CYCLES consecutive synchronized samples, and emits
// one-cycle rise/fall pulses on each accepted change.
module data_debounce
   import data_debounce_pkg::*;
#(
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int CNT_W         = DEF_CNT_W
) (
   input  logic clk,
   input  logic rst_n,
   input  logic data,
   output logic outq,
   output logic rise,
   output logic fall,
   output logic busy
);

   if (STABLE_CYCLES < 2) begin : g_bad_stable
      $error("data_debounce: STABLE_CYCLES must be at least 2");
   end
   if ($clog2(STABLE_CYCLES + 1) > CNT_W) begin : g_bad_cnt_w
      $error("data_debounce: CNT_W too narrow to hold STABLE_CYCLES");
   end

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic             s2;
   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             rise_nxt, fall_nxt;

   sync_2ff u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (data),
      .q     (s2)
   );

   // Level and busy are pure decodes of the state flops, so no input reaches
   // an output without passing through a register.
   assign outq = (state == IDLE_HIGH) || (state == CHK_LOW);
   assign busy = (state == CHK_HIGH)  || (state == CHK_LOW);

   // State, counter and pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE_LOW;
         cnt   <= '0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         rise  <= rise_nxt;
         fall  <= fall_nxt;
      end
   end

   // Next-state logic: count consecutive differing samples, commit on the last
   // one, fall back to the current level on any bounce.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = '0;
      rise_nxt  = 1'b0;
      fall_nxt  = 1'b0;
      case (state)
         IDLE_LOW: begin
            if (s2) begin
               state_nxt = CHK_HIGH;
               cnt_nxt   = CNT_ONE;
            end
         end
         IDLE_HIGH: begin
            if (!s2) begin
               state_nxt = CHK_LOW;
               cnt_nxt   = CNT_ONE;
            end
         end
         CHK_HIGH: begin
            if (!s2) begin
               state_nxt = IDLE_LOW;
            end else if (cnt == CNT_LAST) begin
               state_nxt = IDLE_HIGH;
               rise_nxt  = 1'b1;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         CHK_LOW: begin
            if (s2) begin
               state_nxt = IDLE_HIGH;
            end else if (cnt == CNT_LAST) begin
               state_nxt = IDLE_LOW;
               fall_nxt  = 1'b1;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         default: begin
            state_nxt = IDLE_LOW;
         end
      endcase
   end

endmodule
